core_bus_arb: RTL and testbench

CORE_BUS_ARB -- requirements
Module: core_bus_arb

---
 rtl/core_bus_arb_pkg.sv | 32 +++
 rtl/core_bus_arb_outst_cnt.sv | 57 +++++
 rtl/core_bus_arb.sv | 182 ++++++++++++++++++
 tb/tb_core_bus_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// core_bus_arb_pkg
// Shared definitions for the two-master (fetch/data) bus arbiter:
//   - default values for the starvation limit and outstanding-strobe limit
//   - arb_state_t, the arbiter FSM state type
//   - grant encodings and a helper mapping a state to its one-hot grant
// No ports; imported by core_bus_arb and bus_outst_cnt.
// -----------------------------------------------------------------------------
package core_bus_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned MAX_OUTST_DEF    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_F = 2'b01,
    OWN_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_F    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      OWN_F:   return GRANT_F;
      OWN_D:   return GRANT_D;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/core_bus_arb_outst_cnt.sv
// -----------------------------------------------------------------------------
// bus_outst_cnt
// Counts strobes accepted by the shared slave that have not been acknowledged.
// Ports:
//   clk, rst     clock, synchronous active-low reset (count -> 0)
//   inc          a strobe was accepted this cycle
//   dec          an ack arrived this cycle
//   count        current number of strobes in flight
//   full         count has reached MAX_OUTST
// An ack with nothing in flight is dropped so the count never wraps below 0.
// inc and dec together leave the count unchanged.
// -----------------------------------------------------------------------------
module bus_outst_cnt
  import core_bus_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inc,
  input  logic                           dec,
  output logic [$clog2(MAX_OUTST+1)-1:0] count,
  output logic                           full
);

  localparam int unsigned   CW      = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

  logic [CW-1:0] count_q, count_d;
  logic          inc_eff, dec_eff;

  // Guard both ends: the top never strobes when full, but a stray ack at
  // zero is a real slave behaviour we must tolerate.
  assign dec_eff = dec && (count_q != '0);
  assign inc_eff = inc && (count_q != CNT_MAX);

  always_comb begin
    count_d = count_q;
    if (inc_eff && !dec_eff) begin
      count_d = count_q + CW'(1);
    end else if (dec_eff && !inc_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_MAX);

endmodule

// File: rtl/core_bus_arb.sv
// -----------------------------------------------------------------------------
// core_bus_arb
// Arbitrates a fetch master (f_*) and a data master (d_*) onto one pipelined
// shared slave (s_*). Data wins simultaneous requests, except that a fetch
// request refused for STARVE_LIMIT consecutive cycles wins the next IDLE.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   f_cyc/f_stb/f_we/f_adr/f_dat_mo/f_sel   fetch request in
//   f_ack/f_stall/f_dat_so            fetch response out
//   d_*                               same for the data master
//   s_cyc/s_stb/s_we/s_adr/s_dat_mo/s_sel   shared slave request out
//   s_ack/s_stall/s_dat_so            shared slave response in
//   grant                             01 fetch, 10 data, 00 none
// Handshake: a strobe transfers on any cycle where stb=1 and stall=0; each
// transferred strobe is answered by exactly one ack, in order. The owner's
// request passes through combinationally and s_ack reaches it the same cycle.
// The owner releases the bus only when its cyc is low and nothing is in flight;
// the arbiter then spends one cycle in IDLE before granting again.
// While rst is low every output is 0 except the two stalls, which read 1.
// -----------------------------------------------------------------------------
module core_bus_arb
  import core_bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned MAX_OUTST    = MAX_OUTST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_cyc,
  input  logic        f_stb,
  input  logic        f_we,
  input  logic [31:0] f_adr,
  input  logic [31:0] f_dat_mo,
  input  logic [3:0]  f_sel,
  output logic        f_ack,
  output logic        f_stall,
  output logic [31:0] f_dat_so,
  input  logic        d_cyc,
  input  logic        d_stb,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_dat_mo,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic        d_stall,
  output logic [31:0] d_dat_so,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_mo,
  output logic [3:0]  s_sel,
  input  logic        s_ack,
  input  logic        s_stall,
  input  logic [31:0] s_dat_so,
  output logic [1:0]  grant
);

  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned   CW         = $clog2(MAX_OUTST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [CW-1:0] outst_count;
  logic          outst_full;
  logic          outst_busy;

  logic          own_f, own_d;
  logic          owner_cyc, owner_stb;

  // Ownership is masked by rst so every output falls to its reset value
  // during the reset cycle itself, not one cycle later.
  assign own_f      = rst && (state_q == OWN_F);
  assign own_d      = rst && (state_q == OWN_D);
  assign outst_busy = (outst_count != '0);

  // ---------------------------------------------------------------------------
  // Request path: owner -> shared slave
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_mo  = '0;
    s_sel     = '0;
    if (own_f) begin
      owner_cyc = f_cyc;
      owner_stb = f_stb;
      s_we      = f_we;
      s_adr     = f_adr;
      s_dat_mo  = f_dat_mo;
      s_sel     = f_sel;
    end else if (own_d) begin
      owner_cyc = d_cyc;
      owner_stb = d_stb;
      s_we      = d_we;
      s_adr     = d_adr;
      s_dat_mo  = d_dat_mo;
      s_sel     = d_sel;
    end
  end

  // s_cyc stays up after the owner drops cyc until its last ack returns.
  assign s_cyc = (own_f || own_d) && (owner_cyc || outst_busy);
  assign s_stb = owner_cyc && owner_stb && !outst_full;

  // ---------------------------------------------------------------------------
  // Response path: shared slave -> owner only
  // ---------------------------------------------------------------------------
  assign f_ack    = own_f && s_ack;
  assign f_stall  = !own_f || s_stall || outst_full;
  assign f_dat_so = own_f ? s_dat_so : '0;

  assign d_ack    = own_d && s_ack;
  assign d_stall  = !own_d || s_stall || outst_full;
  assign d_dat_so = own_d ? s_dat_so : '0;

  assign grant = rst ? grant_of(state_q) : GRANT_NONE;

  // ---------------------------------------------------------------------------
  // Outstanding strobe counter
  // ---------------------------------------------------------------------------
  bus_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (s_stb && !s_stall),
    .dec   (s_ack),
    .count (outst_count),
    .full  (outst_full)
  );

  // ---------------------------------------------------------------------------
  // Arbitration FSM and fetch starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (f_cyc && (starve_q == STARVE_MAX)) begin
          state_d = OWN_F;
        end else if (d_cyc) begin
          state_d = OWN_D;
        end else if (f_cyc) begin
          state_d = OWN_F;
        end
      end
      OWN_F: begin
        if (!f_cyc && !outst_busy) begin
          state_d = IDLE;
        end
      end
      OWN_D: begin
        if (!d_cyc && !outst_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counts cycles a pending fetch request goes without the bus.
    starve_d = '0;
    if (f_cyc && (state_q != OWN_F)) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_core_bus_arb
// Self-checking bench for core_bus_arb. The bench plays both masters and the
// shared slave. A reference model tracks the current owner, the fetch wait
// count and the list of in-flight strobe addresses (exp_q); every cycle all
// DUT outputs are compared with values derived from that model.
// -----------------------------------------------------------------------------
module tb_core_bus_arb;

  localparam int STARVE_LIMIT = 8;
  localparam int MAX_OUTST    = 7;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        f_cyc, f_stb, f_we;
  logic [31:0] f_adr, f_dat_mo;
  logic [3:0]  f_sel;
  logic        f_ack, f_stall;
  logic [31:0] f_dat_so;
  logic        d_cyc, d_stb, d_we;
  logic [31:0] d_adr, d_dat_mo;
  logic [3:0]  d_sel;
  logic        d_ack, d_stall;
  logic [31:0] d_dat_so;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_mo;
  logic [3:0]  s_sel;
  logic        s_ack, s_stall;
  logic [31:0] s_dat_so;
  logic [1:0]  grant;

  core_bus_arb dut (
    .clk      (clk),
    .rst      (rst),
    .f_cyc    (f_cyc),
    .f_stb    (f_stb),
    .f_we     (f_we),
    .f_adr    (f_adr),
    .f_dat_mo (f_dat_mo),
    .f_sel    (f_sel),
    .f_ack    (f_ack),
    .f_stall  (f_stall),
    .f_dat_so (f_dat_so),
    .d_cyc    (d_cyc),
    .d_stb    (d_stb),
    .d_we     (d_we),
    .d_adr    (d_adr),
    .d_dat_mo (d_dat_mo),
    .d_sel    (d_sel),
    .d_ack    (d_ack),
    .d_stall  (d_stall),
    .d_dat_so (d_dat_so),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_mo (s_dat_mo),
    .s_sel    (s_sel),
    .s_ack    (s_ack),
    .s_stall  (s_stall),
    .s_dat_so (s_dat_so),
    .grant    (grant)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  int          m_own;          // 0 nobody, 1 fetch, 2 data
  int          m_starve;       // cycles fetch has waited, capped at limit
  logic [31:0] exp_q[$];       // addresses of strobes awaiting ack

  int          ack_pct, stall_pct;
  bit          ack_once;
  bit          last_acc;
  int          n_checks, n_errors;
  int          n_f_ack, n_d_ack, n_acc;

  logic [1:0]  e_grant;
  logic        e_s_cyc, e_s_stb, e_s_we, e_f_ack, e_f_stall, e_d_ack, e_d_stall;
  logic [31:0] e_s_adr, e_s_dat_mo, e_f_dat, e_d_dat;
  logic [3:0]  e_s_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive slave response, check all outputs, advance model.
  // Called at the falling edge with master inputs already set.
  task automatic step();
    int n;
    bit full;
    int next_own;
    logic own_cyc;

    s_stall  = ($urandom_range(99) < stall_pct);
    s_ack    = ack_once || ((exp_q.size() > 0) && ($urandom_range(99) < ack_pct));
    ack_once = 1'b0;
    s_dat_so = (s_ack && exp_q.size() > 0) ? (exp_q[0] ^ 32'h5A5A0F0F) : $urandom();
    #1;

    n    = exp_q.size();
    full = (n == MAX_OUTST);
    e_grant = 2'b00; e_s_cyc = 0; e_s_stb = 0; e_s_we = 0;
    e_s_adr = '0; e_s_dat_mo = '0; e_s_sel = '0;
    e_f_ack = 0; e_f_stall = 1; e_f_dat = '0;
    e_d_ack = 0; e_d_stall = 1; e_d_dat = '0;
    if (rst && m_own == 1) begin
      e_grant = 2'b01;
      e_s_cyc = f_cyc || (n > 0);
      e_s_stb = f_cyc && f_stb && !full;
      e_s_we = f_we; e_s_adr = f_adr; e_s_dat_mo = f_dat_mo; e_s_sel = f_sel;
      e_f_ack = s_ack; e_f_stall = s_stall || full; e_f_dat = s_dat_so;
    end else if (rst && m_own == 2) begin
      e_grant = 2'b10;
      e_s_cyc = d_cyc || (n > 0);
      e_s_stb = d_cyc && d_stb && !full;
      e_s_we = d_we; e_s_adr = d_adr; e_s_dat_mo = d_dat_mo; e_s_sel = d_sel;
      e_d_ack = s_ack; e_d_stall = s_stall || full; e_d_dat = s_dat_so;
    end

    chk("grant",    32'(grant),    32'(e_grant));
    chk("s_cyc",    32'(s_cyc),    32'(e_s_cyc));
    chk("s_stb",    32'(s_stb),    32'(e_s_stb));
    chk("s_we",     32'(s_we),     32'(e_s_we));
    chk("s_sel",    32'(s_sel),    32'(e_s_sel));
    chk("s_adr",    s_adr,         e_s_adr);
    chk("s_dat_mo", s_dat_mo,      e_s_dat_mo);
    chk("f_ack",    32'(f_ack),    32'(e_f_ack));
    chk("f_stall",  32'(f_stall),  32'(e_f_stall));
    chk("f_dat_so", f_dat_so,      e_f_dat);
    chk("d_ack",    32'(d_ack),    32'(e_d_ack));
    chk("d_stall",  32'(d_stall),  32'(e_d_stall));
    chk("d_dat_so", d_dat_so,      e_d_dat);

    if (f_ack) n_f_ack++;
    if (d_ack) n_d_ack++;
    if (s_stb && !s_stall) n_acc++;
    last_acc = e_s_stb && !s_stall;

    @(posedge clk);
    if (!rst) begin
      m_own    = 0;
      m_starve = 0;
      exp_q.delete();
    end else begin
      own_cyc  = (m_own == 1) ? f_cyc : (m_own == 2) ? d_cyc : 1'b0;
      next_own = m_own;
      if (m_own == 0) begin
        if (f_cyc && m_starve == STARVE_LIMIT) next_own = 1;
        else if (d_cyc)                        next_own = 2;
        else if (f_cyc)                        next_own = 1;
      end else if (!own_cyc && n == 0) begin
        next_own = 0;
      end
      if (s_ack && n > 0) void'(exp_q.pop_front());
      if (e_s_stb && !s_stall) exp_q.push_back(e_s_adr);
      if (f_cyc && m_own != 1) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else                     m_starve = 0;
      m_own = next_own;
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_masters();
    f_cyc = 0; f_stb = 0; f_we = 0; f_adr = '0; f_dat_mo = '0; f_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_mo = '0; d_sel = '0;
  endtask

  task automatic reset_dut();
    idle_masters();
    ack_pct = 0; stall_pct = 0;
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  // Present one strobe and hold it until the arbiter takes it.
  task automatic strobe(input bit is_d, input logic [31:0] a);
    bit done;
    done = 0;
    if (is_d) begin
      d_stb = 1; d_adr = a; d_we = 1; d_dat_mo = ~a; d_sel = 4'hF;
    end else begin
      f_stb = 1; f_adr = a; f_we = 0; f_dat_mo = '0; f_sel = 4'hF;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = last_acc;
    end
    if (is_d) begin
      chk("d_strobe_taken", 32'(done), 32'd1);
      d_stb = 0;
    end else begin
      chk("f_strobe_taken", 32'(done), 32'd1);
      f_stb = 0;
    end
  endtask

  task automatic drain();
    int left;
    f_stb = 0; d_stb = 0; ack_pct = 100; stall_pct = 0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    left = exp_q.size();
    chk("drain_timeout", 32'(left), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0; n_errors = 0;
    m_own = 0; m_starve = 0; ack_once = 0; last_acc = 0;
    ack_pct = 0; stall_pct = 0;
    idle_masters();
    rst = 0; s_ack = 0; s_stall = 0; s_dat_so = '0;
    @(negedge clk);
    reset_dut();

    // Fetch-only burst of three reads, slave acks one cycle later.
    ack_pct = 100; n_f_ack = 0; n_d_ack = 0;
    f_cyc = 1;
    for (int i = 0; i < 3; i++) strobe(1'b0, 32'(i * 4));
    drain();
    f_cyc = 0;
    step();
    step();
    chk("t1_f_acks", 32'(n_f_ack), 32'd3);
    chk("t1_d_acks", 32'(n_d_ack), 32'd0);
    chk("t1_grant_end", 32'(grant), 32'd0);

    // Simultaneous requests: data first, one idle cycle, then fetch.
    reset_dut();
    ack_pct = 100;
    f_cyc = 1; d_cyc = 1;
    step();
    chk("t2_grant_d", 32'(grant), 32'b10);
    strobe(1'b1, 32'h0000_0100);
    drain();
    d_cyc = 0;
    step();
    chk("t2_idle_gap", 32'(grant), 32'b00);
    step();
    chk("t2_grant_f", 32'(grant), 32'b01);
    f_cyc = 0;
    step();
    step();

    // Long data ownership starves fetch; fetch wins the next IDLE.
    reset_dut();
    f_cyc = 1; d_cyc = 1;
    repeat (20) step();
    chk("t3_grant_d", 32'(grant), 32'b10);
    d_cyc = 0;
    step();
    chk("t3_idle", 32'(grant), 32'b00);
    d_cyc = 1;
    step();
    chk("t3_starve_win", 32'(grant), 32'b01);
    d_cyc = 0; f_cyc = 0;
    step();
    step();

    // Silent slave: outstanding limit throttles strobes.
    reset_dut();
    f_cyc = 1; f_stb = 1; f_sel = 4'h3; n_acc = 0;
    for (int i = 0; i < 12; i++) begin f_adr = $urandom(); step(); end
    chk("t4_accepted", 32'(n_acc), 32'd7);
    chk("t4_stall", 32'(f_stall), 32'd1);
    chk("t4_stb_off", 32'(s_stb), 32'd0);
    ack_once = 1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin f_adr = $urandom(); step(); end
    chk("t4_one_more", 32'(n_acc), 32'd1);
    drain();
    f_cyc = 0;
    step();
    step();

    // Data owner drops cyc with three strobes in flight.
    reset_dut();
    d_cyc = 1;
    for (int i = 0; i < 3; i++) strobe(1'b1, 32'h0000_2000 + 32'(i));
    d_cyc = 0;
    repeat (3) step();
    chk("t5_cyc_held", 32'(s_cyc), 32'd1);
    chk("t5_grant_held", 32'(grant), 32'b10);
    ack_once = 1; step();
    ack_once = 1; step();
    chk("t5_hold_2", 32'(grant), 32'b10);
    chk("t5_cyc_2", 32'(s_cyc), 32'd1);
    ack_once = 1; step();
    chk("t5_cyc_drop", 32'(s_cyc), 32'd0);
    step();
    chk("t5_release", 32'(grant), 32'b00);

    // Reset with four strobes in flight; later stray ack must be ignored.
    reset_dut();
    f_cyc = 1;
    for (int i = 0; i < 4; i++) strobe(1'b0, 32'h0000_3000 + 32'(i * 4));
    rst = 0;
    step();
    rst = 1;
    #1;
    chk("t6_grant", 32'(grant), 32'b00);
    chk("t6_s_cyc", 32'(s_cyc), 32'd0);
    f_cyc = 0; ack_once = 1;
    step();
    step();
    f_cyc = 1; f_stb = 1; n_acc = 0;
    for (int i = 0; i < 12; i++) begin f_adr = $urandom(); step(); end
    chk("t6_no_underflow", 32'(n_acc), 32'd7);
    drain();
    f_cyc = 0;
    step();
    step();

    // Randomized traffic from both masters with a randomly slow slave.
    reset_dut();
    ack_pct = 40; stall_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0)  f_cyc = ~f_cyc;
      if ($urandom_range(11) == 0) d_cyc = ~d_cyc;
      f_stb = f_cyc && ($urandom_range(1) == 1);
      d_stb = d_cyc && ($urandom_range(1) == 1);
      f_we = $urandom_range(1); f_adr = $urandom(); f_dat_mo = $urandom(); f_sel = 4'($urandom());
      d_we = $urandom_range(1); d_adr = $urandom(); d_dat_mo = $urandom(); d_sel = 4'($urandom());
      rst = ($urandom_range(399) != 0);
      step();
    end
    rst = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
